// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// regfile_wb_pkg : shared register selectors, width codes and queue entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  localparam logic [1:0] WB_WIDTH_BYTE    = 2'b00;
  localparam logic [1:0] WB_WIDTH_WORD    = 2'b01;
  localparam logic [1:0] WB_WIDTH_DWORD   = 2'b10;
  localparam logic [1:0] WB_WIDTH_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [2:0]  regsel;
    logic [1:0]  width;
    logic [31:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_if.sv
// ============================================================================
// regfile_wb_if : write-back request channel (valid/ready plus payload)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_regsel;
  logic [1:0]  wb_width;
  logic [31:0] wb_data;

  modport master (output wb_valid, output wb_regsel, output wb_width,
                  output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_regsel, input wb_width,
                  input wb_data, output wb_ready);
endinterface

`default_nettype wire

// File: rtl/regfile_wb_merge.sv
// ============================================================================
// wb_merge : merges a right-aligned write value into an old register value
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_merge
  import regfile_wb_pkg::*;
(
  input  wire logic [31:0] old_val,
  input  wire logic [31:0] data,
  input  wire logic [1:0]  width,
  input  wire logic        hi_byte,
  output logic      [31:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (width)
      WB_WIDTH_BYTE: begin
        if (hi_byte) new_val[15:8] = data[7:0];
        else         new_val[7:0]  = data[7:0];
      end
      WB_WIDTH_WORD:  new_val[15:0] = data[15:0];
      WB_WIDTH_DWORD: new_val       = data;
      default:        new_val       = old_val;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb.sv
// ============================================================================
// regfile_wb : 8x32 register file fed by a 2-entry in-order write-back queue
// Optional: REGFILE_WB_FWD_EN forwards the queue head onto the outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb
  import regfile_wb_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst_n,
  regfile_wb_if.slave wb,
  input  wire logic  hold,
  output logic [31:0] eax,
  output logic [31:0] ecx,
  output logic [31:0] edx,
  output logic [31:0] ebx,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic [31:0] esi,
  output logic [31:0] edi,
  output logic [1:0]  wb_pending,
  output logic        retire,
  output logic        wb_err
);

  logic [31:0] r_regs [8];
  wb_entry_t   r_fifo [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_retire;
  logic        r_err;

  wb_entry_t   w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_hi;
  logic [2:0]  w_tgt;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic [31:0] w_out [8];

  assign wb.wb_ready = (r_count != 2'd2);
  assign w_push      = wb.wb_valid && wb.wb_ready;
  assign w_pop       = (r_count != 2'd0) && !hold;
  assign w_head      = r_fifo[r_rd_ptr];

  // Byte writes to selectors 4..7 land in bits 15:8 of eax..ebx
  assign w_hi  = (w_head.width == WB_WIDTH_BYTE) && w_head.regsel[2];
  assign w_tgt = w_hi ? {1'b0, w_head.regsel[1:0]} : w_head.regsel;
  assign w_old = r_regs[w_tgt];

  wb_merge u_merge (
    .old_val (w_old),
    .data    (w_head.data),
    .width   (w_head.width),
    .hi_byte (w_hi),
    .new_val (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_retire <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_retire <= w_pop;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {wb.wb_regsel, wb.wb_width, wb.wb_data};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr      <= ~r_rd_ptr;
        r_regs[w_tgt] <= w_merged;
        if (w_head.width == WB_WIDTH_ILLEGAL) r_err <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_out
`ifdef REGFILE_WB_FWD_EN
    assign w_out[i] = ((r_count != 2'd0) && (w_tgt == 3'(i))) ? w_merged : r_regs[i];
`else
    assign w_out[i] = r_regs[i];
`endif
  end

  assign eax        = w_out[0];
  assign ecx        = w_out[1];
  assign edx        = w_out[2];
  assign ebx        = w_out[3];
  assign esp        = w_out[4];
  assign ebp        = w_out[5];
  assign esi        = w_out[6];
  assign edi        = w_out[7];
  assign wb_pending = r_count;
  assign retire     = r_retire;
  assign wb_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
// ============================================================================
// tb_regfile_wb : vector table plus scoreboard-checked bench for regfile_wb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb;
  import regfile_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
  logic [1:0]  wb_pending;
  logic        retire;
  logic        wb_err;

  always #5 clk = ~clk;

  regfile_wb_if wb_if ();

  regfile_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb_if),
    .hold       (hold),
    .eax        (eax),
    .ecx        (ecx),
    .edx        (edx),
    .ebx        (ebx),
    .esp        (esp),
    .ebp        (ebp),
    .esi        (esi),
    .edi        (edi),
    .wb_pending (wb_pending),
    .retire     (retire),
    .wb_err     (wb_err)
  );

  typedef struct {
    logic [2:0]  regsel;
    logic [1:0]  width;
    logic [31:0] data;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  wb_entry_t   sb [$];
  logic [31:0] m_regs [8];
  logic        m_err;
  vec_t        vecs [12];

  function automatic logic [31:0] dut_reg(int i);
    case (i)
      0: return eax;
      1: return ecx;
      2: return edx;
      3: return ebx;
      4: return esp;
      5: return ebp;
      6: return esi;
      default: return edi;
    endcase
  endfunction

  // Reference effect of one request on register i
  function automatic logic [31:0] model_apply(logic [31:0] old, wb_entry_t e, int i);
    int sel;
    sel = int'(e.regsel);
    case (e.width)
      2'b10: if (sel == i) return e.data;
      2'b01: if (sel == i) return {old[31:16], e.data[15:0]};
      2'b00: begin
        if (sel < 4 && sel == i)      return {old[31:8], e.data[7:0]};
        if (sel >= 4 && sel - 4 == i) return {old[31:16], e.data[7:0], old[7:0]};
      end
      default: ;
    endcase
    return old;
  endfunction

  function automatic logic [31:0] exp_out(int i);
    logic [31:0] v;
    v = m_regs[i];
`ifdef REGFILE_WB_FWD_EN
    if (sb.size() != 0) v = model_apply(v, sb[0], i);
`endif
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_err = 1'b0;
  endtask

  // Advance one edge; record acceptance and score any retirement
  task automatic step();
    logic      acc;
    wb_entry_t e;
    acc = wb_if.wb_valid && wb_if.wb_ready;
    e   = {wb_if.wb_regsel, wb_if.wb_width, wb_if.wb_data};
    @(posedge clk);
    #1;
    if (acc && rst_n) sb.push_back(e);
    if (rst_n && retire) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got retire expected none");
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) m_regs[i] = model_apply(m_regs[i], e, i);
        if (e.width == 2'b11) m_err = 1'b1;
        for (int i = 0; i < 8; i++) chk($sformatf("sb_r%0d", i), dut_reg(i), exp_out(i));
        chk("sb_err", 32'(wb_err), 32'(m_err));
        chk("sb_pending", 32'(wb_pending), 32'(sb.size()));
      end
    end
  endtask

  task automatic send(logic [2:0] sel, logic [1:0] w, logic [31:0] d);
    int n;
    wb_if.wb_valid  = 1'b1;
    wb_if.wb_regsel = sel;
    wb_if.wb_width  = w;
    wb_if.wb_data   = d;
    n = 0;
    while (!wb_if.wb_ready && n < 20) begin
      step();
      n++;
    end
    if (!wb_if.wb_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    step();
    wb_if.wb_valid = 1'b0;
  endtask

  task automatic wait_retire();
    int n;
    n = 0;
    while (!retire && n < 10) begin
      step();
      n++;
    end
    total++;
    if (!retire) begin
      bad++;
      $display("FAIL retire_timeout: got retire=0 expected retire=1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd0, 2'b10, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[1]  = '{3'd3, 2'b10, 32'h11223344, 3, 32'h11223344};
    vecs[2]  = '{3'd7, 2'b00, 32'h000000AB, 3, 32'h1122AB44};
    vecs[3]  = '{3'd3, 2'b00, 32'hFFFFFF55, 3, 32'h1122AB55};
    vecs[4]  = '{3'd1, 2'b10, 32'h12340000, 1, 32'h12340000};
    vecs[5]  = '{3'd1, 2'b01, 32'hABCD5678, 1, 32'h12345678};
    vecs[6]  = '{3'd4, 2'b00, 32'h00000012, 0, 32'hDEAD12EF};
    vecs[7]  = '{3'd6, 2'b01, 32'h0000BEEF, 6, 32'h0000BEEF};
    vecs[8]  = '{3'd7, 2'b10, 32'hCAFEF00D, 7, 32'hCAFEF00D};
    vecs[9]  = '{3'd0, 2'b00, 32'h00000077, 0, 32'hDEAD1277};
    vecs[10] = '{3'd5, 2'b00, 32'h0000009A, 1, 32'h12349A78};
    vecs[11] = '{3'd4, 2'b01, 32'h00001234, 4, 32'h00001234};

    wb_if.wb_valid  = 1'b0;
    wb_if.wb_regsel = '0;
    wb_if.wb_width  = '0;
    wb_if.wb_data   = '0;
    hold  = 1'b0;
    rst_n = 1'b0;
    model_reset();

    #12;
    chk("rst_ready", 32'(wb_if.wb_ready), 32'd1);
    chk("rst_pending", 32'(wb_pending), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_eax", eax, 32'd0);
    chk("rst_edi", edi, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(wb_if.wb_ready), 32'd1);

    for (int k = 0; k < 12; k++) begin
      send(vecs[k].regsel, vecs[k].width, vecs[k].data);
      wait_retire();
      chk($sformatf("vec%0d", k), dut_reg(vecs[k].idx), vecs[k].exp);
    end
    step();
    chk("retire_one_cycle", 32'(retire), 32'd0);

    // Back-pressure with hold, then in-order drain and late accept
    hold = 1'b1;
    send(REG_EDX, WB_WIDTH_DWORD, 32'h01020304);
    send(3'd6, WB_WIDTH_BYTE, 32'h000000EE);
    chk("bp_ready", 32'(wb_if.wb_ready), 32'd0);
    chk("bp_pending", 32'(wb_pending), 32'd2);
    wb_if.wb_valid  = 1'b1;
    wb_if.wb_regsel = REG_EDX;
    wb_if.wb_width  = WB_WIDTH_WORD;
    wb_if.wb_data   = 32'h0000A5A5;
    step();
    chk("bp_hold_pending", 32'(wb_pending), 32'd2);
    chk("bp_hold_retire", 32'(retire), 32'd0);
    hold = 1'b0;
    step();
    chk("bp_ret1", 32'(retire), 32'd1);
    chk("bp_pend1", 32'(wb_pending), 32'd1);
    step();
    wb_if.wb_valid = 1'b0;
    chk("bp_ret2", 32'(retire), 32'd1);
    chk("bp_pend2", 32'(wb_pending), 32'd1);
    step();
    chk("bp_ret3", 32'(retire), 32'd1);
    chk("bp_pend3", 32'(wb_pending), 32'd0);
    chk("bp_edx", edx, 32'h0102A5A5);

    // Illegal width leaves registers alone and latches the error
    send(REG_EAX, WB_WIDTH_ILLEGAL, 32'hFFFFFFFF);
    wait_retire();
    chk("ill_err", 32'(wb_err), 32'd1);
    chk("ill_eax", eax, 32'hDEAD1277);
    send(REG_EBP, WB_WIDTH_DWORD, 32'h0BADF00D);
    wait_retire();
    chk("ill_err_sticky", 32'(wb_err), 32'd1);
    chk("ill_ebp", ebp, 32'h0BADF00D);

    // Pending word write seen (or not) through the forward path
    send(REG_ECX, WB_WIDTH_DWORD, 32'h12340000);
    wait_retire();
    hold = 1'b1;
    send(REG_ECX, WB_WIDTH_WORD, 32'h00005678);
`ifdef REGFILE_WB_FWD_EN
    chk("fwd_ecx", ecx, 32'h12345678);
`else
    chk("fwd_ecx", ecx, 32'h12340000);
`endif
    chk("fwd_pending", 32'(wb_pending), 32'd1);
    step();
    chk("fwd_no_retire", 32'(retire), 32'd0);
    hold = 1'b0;
    wait_retire();
    chk("fwd_ecx_final", ecx, 32'h12345678);

    // Reset between edges with a full queue
    hold = 1'b1;
    send(REG_EAX, WB_WIDTH_DWORD, 32'h00000001);
    send(REG_ESI, WB_WIDTH_DWORD, 32'h00000002);
    chk("mq_pending", 32'(wb_pending), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mq_pending0", 32'(wb_pending), 32'd0);
    chk("mq_eax", eax, 32'd0);
    chk("mq_ecx", ecx, 32'd0);
    chk("mq_esi", esi, 32'd0);
    chk("mq_err", 32'(wb_err), 32'd0);
    chk("mq_ready", 32'(wb_if.wb_ready), 32'd1);
    model_reset();
    hold = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mq_post_retire", 32'(retire), 32'd0);
    step();
    chk("mq_post_eax", eax, 32'd0);
    chk("mq_post_esi", esi, 32'd0);
    chk("mq_post_pending", 32'(wb_pending), 32'd0);
    chk("mq_post_ready", 32'(wb_if.wb_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have clock port `clk`, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-002 SHALL have reset port `rst_n`, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have `wb_valid`, input, 1 bit: a write-back request is presented.
REQ-004 SHALL have `wb_ready`, output, 1 bit: the queue can accept a request.
REQ-005 SHALL have `wb_regsel`, input, 3 bits: register selector, encoded with the shared `REG_*` constants.
REQ-006 SHALL have `wb_width`, input, 2 bits: 00 byte, 01 word, 10 dword, 11 illegal.
REQ-007 SHALL have `wb_data`, input, 32 bits: the write value, right-aligned.
REQ-008 SHALL have `hold`, input, 1 bit: freezes retirement while the decoder samples operands.
REQ-009 SHALL have `eax, ecx, edx, ebx, esp, ebp, esi, edi`, outputs, 32 bits each: architectural register values.
REQ-010 SHALL have `wb_pending`, output, 2 bits: the number of queued requests (0..2).
REQ-011 SHALL have `retire`, output, 1 bit: one-cycle pulse when a request is applied.
REQ-012 SHALL have `wb_err`, output, 1 bit: sticky flag, set on an illegal width.

Function
REQ-013 SHALL hold a 2-entry in-order FIFO of {regsel, width, data}.
REQ-014 SHALL drive `wb_ready` = (`wb_pending` != 2), combinationally from registered count only.
REQ-015 SHALL enqueue on a rising edge when `wb_valid` && `wb_ready`.
REQ-016 SHALL retire the head entry on each rising edge where `wb_pending` != 0 and `hold` = 0.
- Minimum latency: accept at edge N, visible on outputs after edge N+1.
REQ-017 SHALL, on simultaneous enqueue and retire, leave the count unchanged and preserve order.
- When full, `wb_ready` = 0, so no enqueue occurs even if retirement frees a slot that cycle.
REQ-018 SHALL apply byte writes as follows:
- regsel 0-3 writes bits 7:0 of eax/ecx/edx/ebx.
- regsel 4-7 writes bits 15:8 of eax/ecx/edx/ebx (AH/CH/DH/BH).
- All other bits unchanged.
REQ-019 SHALL apply word writes to bits 15:0 of the selected register; bits 31:16 unchanged.
REQ-020 SHALL apply dword writes by replacing all 32 bits.
REQ-021 SHALL, on retiring an entry with width 11, modify no register, still pulse `retire`, and set `wb_err`.
REQ-022 SHALL pulse `retire` high for exactly the cycle following each retiring edge.
REQ-023 SHALL use pointer wrap-around modulo 2; the count SHALL never exceed 2 or underflow below 0.

Reset
REQ-024 SHALL, on `rst_n` low, asynchronously clear:
- all registers, `wb_pending`, `retire`, `wb_err` to 0;
- both FIFO pointers.
REQ-025 SHALL discard queued entries when reset asserts mid-operation.
REQ-026 SHALL drive `wb_ready` = 1 during and immediately after reset.

Configuration
REQ-027 SHALL, with `REGFILE_WB_FWD_EN` defined, drive each register output as if the head entry were already applied whenever `wb_pending` != 0 (combinational forward of the head entry only).
REQ-028 SHALL, without `REGFILE_WB_FWD_EN`, drive the outputs from architectural state only.

Structure
REQ-029 SHALL take `REG_*` selectors from the shared defines file.
REQ-030 SHALL place `WB_WIDTH_BYTE`, `WB_WIDTH_WORD`, `WB_WIDTH_DWORD` constants in that shared file.
REQ-031 SHALL factor the byte/word/dword merge into combinational sub-module `wb_merge` (old value, data, width, high-byte flag -> new value).
- Used by both retire and forward paths.

Verification
REQ-032 Dword write: regsel=EAX, width=10, data=0xDEADBEEF -> eax=0xDEADBEEF two edges after accept; `retire` pulses once.
REQ-033 Byte-high write: ebx=0x11223344, then regsel=7 (BH), width=00, data=0xAB -> ebx=0x1122AB44.
REQ-034 Back-pressure: `hold`=1, send 3 requests -> `wb_ready`=0 after 2, `wb_pending`=2; release `hold` -> in-order retire on 2 consecutive edges; third request then accepted.
REQ-035 Illegal width: width=11, data=0xFFFFFFFF -> all registers unchanged, `wb_err`=1 and stays 1 until reset.
REQ-036 Reset mid-queue: 2 entries pending, pulse `rst_n` low between edges -> `wb_pending`=0 and all registers 0 immediately; the entries are never applied.
REQ-037 With `REGFILE_WB_FWD_EN`: `hold`=1, queue word write ecx=0x5678 over 0x12340000 -> ecx output reads 0x12345678 while pending; without the macro it reads 0x12340000.
